// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes, arbiter FSM states
// and the result values reported alongside an error response.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } arb_state_e;

  localparam logic [7:0] ERR_DATA_DIV0    = 8'hFF;
  localparam logic [7:0] ERR_DATA_TIMEOUT = 8'h00;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant logic.
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset (pointer back to requester 0)
//   i_req     request vector, bit N = requester N
//   i_accept  grant consumed this cycle
//   o_gnt     one-hot grant (all zero when nothing requests)
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // r_ptr names the requester that wins a tie.
  logic r_ptr;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // Only a contested grant moves the pointer; a lone requester leaves it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_accept && (i_req == 2'b11)) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one operation in flight.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid_N/a_N/b_N/op_N    operation request from requester N
//   req_ready_N                 request N accepted this cycle (IDLE only)
//   resp_valid_N/data_N/err_N   one-cycle response to requester N
//   alu_in/alu_op_codes         {A,B} and op code towards the ALU
//   alu_valid                   one-cycle launch pulse
//   alu_o/alu_ready             ALU result and its valid strobe
//
// state | meaning
// IDLE  | waiting for a request, grant via round-robin
// ISSUE | launch pulse to the ALU, load wait timer
// WAIT  | waiting for alu_ready or timer expiry
// RESP  | one-cycle response to the owning requester
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  input  logic [7:0]  req_a_0,
  input  logic [7:0]  req_b_0,
  input  logic [1:0]  req_op_0,
  output logic        req_ready_0,
  output logic        resp_valid_0,
  output logic [7:0]  resp_data_0,
  output logic        resp_err_0,
  input  logic        req_valid_1,
  input  logic [7:0]  req_a_1,
  input  logic [7:0]  req_b_1,
  input  logic [1:0]  req_op_1,
  output logic        req_ready_1,
  output logic        resp_valid_1,
  output logic [7:0]  resp_data_1,
  output logic        resp_err_1,
  output logic [15:0] alu_in,
  output logic [1:0]  alu_op_codes,
  output logic        alu_valid,
  input  logic [7:0]  alu_o,
  input  logic        alu_ready
);

  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

  arb_state_e r_state, w_state_nxt;
  logic [7:0] r_a, r_b, r_data, r_wait_cnt;
  alu_op_e    r_op;
  logic       r_owner, r_err;

  logic [1:0] w_req, w_gnt;
  logic       w_accept, w_div0, w_resp;
  logic [7:0] w_sel_a, w_sel_b;
  logic [1:0] w_sel_op;

  // Requests are only offered while idle and out of reset, so req_ready
  // stays low during reset even with req_valid held high.
  assign w_req = (r_state == ST_IDLE && rst) ? {req_valid_1, req_valid_0} : 2'b00;

  rr_arbiter2 u_arb (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  assign w_accept = |w_gnt;
  assign w_sel_a  = w_gnt[1] ? req_a_1  : req_a_0;
  assign w_sel_b  = w_gnt[1] ? req_b_1  : req_b_0;
  assign w_sel_op = w_gnt[1] ? req_op_1 : req_op_0;
  assign w_div0   = (w_sel_op == OP_DIV) && (w_sel_b == 8'h00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    alu_valid    = 1'b0;
    w_resp       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_0 = w_gnt[0];
        req_ready_1 = w_gnt[1];
        if (w_accept) begin
          w_state_nxt = w_div0 ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_valid   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_ready || (r_wait_cnt == 8'd0)) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_op       <= OP_ADD;
      r_owner    <= 1'b0;
      r_data     <= 8'h00;
      r_err      <= 1'b0;
      r_wait_cnt <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= alu_op_e'(w_sel_op);
            r_owner <= w_gnt[1];
            r_data  <= ERR_DATA_DIV0;
            r_err   <= w_div0;
          end
        end
        ST_ISSUE: r_wait_cnt <= WAIT_LOAD;
        ST_WAIT: begin
          // Down-counter: the WAIT cycle that sees zero is the TIMEOUT-th.
          if (alu_ready) begin
            r_data <= alu_o;
            r_err  <= 1'b0;
          end else if (r_wait_cnt == 8'd0) begin
            r_data <= ERR_DATA_TIMEOUT;
            r_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_in       = {r_a, r_b};
  assign alu_op_codes = r_op;

  assign resp_valid_0 = w_resp && !r_owner;
  assign resp_valid_1 = w_resp &&  r_owner;
  assign resp_data_0  = resp_valid_0 ? r_data : 8'h00;
  assign resp_data_1  = resp_valid_1 ? r_data : 8'h00;
  assign resp_err_0   = resp_valid_0 & r_err;
  assign resp_err_1   = resp_valid_1 & r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic [7:0]  req_a_0, req_b_0, req_a_1, req_b_1;
  logic [1:0]  req_op_0, req_op_1;
  logic        req_ready_0, req_ready_1;
  logic        resp_valid_0, resp_valid_1;
  logic [7:0]  resp_data_0, resp_data_1;
  logic        resp_err_0, resp_err_1;
  logic [15:0] alu_in;
  logic [1:0]  alu_op_codes;
  logic        alu_valid;
  logic [7:0]  alu_o;
  logic        alu_ready;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_0  (req_valid_0),
    .req_a_0      (req_a_0),
    .req_b_0      (req_b_0),
    .req_op_0     (req_op_0),
    .req_ready_0  (req_ready_0),
    .resp_valid_0 (resp_valid_0),
    .resp_data_0  (resp_data_0),
    .resp_err_0   (resp_err_0),
    .req_valid_1  (req_valid_1),
    .req_a_1      (req_a_1),
    .req_b_1      (req_b_1),
    .req_op_1     (req_op_1),
    .req_ready_1  (req_ready_1),
    .resp_valid_1 (resp_valid_1),
    .resp_data_1  (resp_data_1),
    .resp_err_1   (resp_err_1),
    .alu_in       (alu_in),
    .alu_op_codes (alu_op_codes),
    .alu_valid    (alu_valid),
    .alu_o        (alu_o),
    .alu_ready    (alu_ready)
  );

  always #5 clk = ~clk;

  // ALU model: answers alu_k cycles after the launch pulse when enabled.
  logic       alu_en = 1'b1;
  int         alu_k = 1;
  int         alu_cnt = 0;
  logic [7:0] alu_res = 8'h00;
  int         n_launch = 0;

  function automatic logic [7:0] alu_f(input logic [15:0] in, input logic [1:0] op);
    logic [7:0] a, b, r;
    a = in[15:8];
    b = in[7:0];
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: r = a * b;
      default: r = (b == 8'h00) ? 8'h00 : a / b;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    alu_ready = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt = alu_cnt - 1;
      if (alu_cnt == 0) begin
        alu_ready = 1'b1;
        alu_o     = alu_res;
      end
    end
    if (alu_valid) n_launch = n_launch + 1;
    if (alu_valid && alu_en) begin
      alu_cnt = alu_k;
      alu_res = alu_f(alu_in, alu_op_codes);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Steps until resp_valid_<idx>; cyc = edges taken, -1 if none in budget.
  task automatic wait_resp(input int idx, input int max_cyc, output int cyc,
                           output logic [7:0] d, output logic e);
    cyc = -1;
    d   = 8'h00;
    e   = 1'b0;
    for (int i = 1; i <= max_cyc && cyc < 0; i++) begin
      step();
      if ((idx == 0) ? resp_valid_0 : resp_valid_1) begin
        cyc = i;
        d   = (idx == 0) ? resp_data_0 : resp_data_1;
        e   = (idx == 0) ? resp_err_0  : resp_err_1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    #1;
    n_vec++;
    if ({req_ready_0, req_ready_1, alu_valid, resp_valid_0, resp_valid_1, resp_err_0, resp_err_1} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {req_ready_0, req_ready_1, alu_valid, resp_valid_0, resp_valid_1, resp_err_0, resp_err_1});
    end
    n_vec++;
    if ({alu_in, alu_op_codes, resp_data_0, resp_data_1} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_data: got alu_in=%h op=%b d0=%h d1=%h expected all 0",
               alu_in, alu_op_codes, resp_data_0, resp_data_1);
    end
    step();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    int cyc; logic [7:0] d; logic e; logic r1;
    alu_k = 1;
    req_valid_0 = 1'b1; req_a_0 = 8'd25; req_b_0 = 8'd17; req_op_0 = 2'b00;
    #1;
    n_vec++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin
      n_err++;
      $display("FAIL single_ready: got %b expected 10", {req_ready_0, req_ready_1});
    end
    step();
    req_valid_0 = 1'b0;
    n_vec++;
    if ({alu_valid, alu_in, alu_op_codes} !== {1'b1, 16'h1911, 2'b00}) begin
      n_err++;
      $display("FAIL single_issue: got valid=%b in=%h op=%b expected 1 1911 00", alu_valid, alu_in, alu_op_codes);
    end
    step();
    n_vec++;
    if ({alu_valid, alu_in} !== {1'b0, 16'h1911}) begin
      n_err++;
      $display("FAIL single_wait: got valid=%b in=%h expected 0 1911", alu_valid, alu_in);
    end
    wait_resp(0, 20, cyc, d, e);
    r1 = resp_valid_1;
    n_vec++;
    if (cyc + 2 !== 3) begin
      n_err++;
      $display("FAIL single_latency: got %0d expected 3", cyc + 2);
    end
    n_vec++;
    if ({d, e, r1} !== {8'd42, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL single_resp: got data=%0d err=%b v1=%b expected 42 0 0", d, e, r1);
    end
    step();
    n_vec++;
    if ({resp_valid_0, resp_data_0, resp_err_0} !== 10'h0) begin
      n_err++;
      $display("FAIL single_after: got v=%b d=%h e=%b expected 0 00 0", resp_valid_0, resp_data_0, resp_err_0);
    end
  endtask

  task automatic test_contention();
    int cyc; logic [7:0] d; logic e;
    do_reset();
    alu_k = 2;
    req_valid_0 = 1'b1; req_a_0 = 8'd5;  req_b_0 = 8'd3;  req_op_0 = 2'b10;
    req_valid_1 = 1'b1; req_a_1 = 8'd40; req_b_1 = 8'd15; req_op_1 = 2'b01;
    #1;
    n_vec++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin
      n_err++;
      $display("FAIL cont_grant: got %b expected 10", {req_ready_0, req_ready_1});
    end
    step();
    req_valid_0 = 1'b0;
    n_vec++;
    if (dut.u_arb.r_ptr !== 1'b1) begin
      n_err++;
      $display("FAIL cont_ptr: got %b expected 1", dut.u_arb.r_ptr);
    end
    n_vec++;
    if (req_ready_1 !== 1'b0) begin
      n_err++;
      $display("FAIL cont_holdoff: got %b expected 0", req_ready_1);
    end
    wait_resp(0, 20, cyc, d, e);
    n_vec++;
    if ({d, e} !== {8'd15, 1'b0} || cyc < 0) begin
      n_err++;
      $display("FAIL cont_resp0: got data=%0d err=%b cyc=%0d expected 15 0", d, e, cyc);
    end
    n_vec++;
    if (req_ready_1 !== 1'b0) begin
      n_err++;
      $display("FAIL cont_holdoff_resp: got %b expected 0", req_ready_1);
    end
    step();
    n_vec++;
    if (req_ready_1 !== 1'b1) begin
      n_err++;
      $display("FAIL cont_grant1: got %b expected 1", req_ready_1);
    end
    step();
    req_valid_1 = 1'b0;
    wait_resp(1, 20, cyc, d, e);
    n_vec++;
    if ({d, e} !== {8'd25, 1'b0} || cyc < 0) begin
      n_err++;
      $display("FAIL cont_resp1: got data=%0d err=%b cyc=%0d expected 25 0", d, e, cyc);
    end
  endtask

  task automatic test_fairness();
    int who; logic [7:0] d;
    do_reset();
    alu_k = 2;
    req_valid_0 = 1'b1; req_a_0 = 8'd1;  req_b_0 = 8'd2;  req_op_0 = 2'b00;
    req_valid_1 = 1'b1; req_a_1 = 8'd10; req_b_1 = 8'd20; req_op_1 = 2'b00;
    for (int op = 0; op < 4; op++) begin
      who = -1;
      d   = 8'h00;
      for (int i = 0; i < 30 && who < 0; i++) begin
        step();
        if (resp_valid_0) begin who = 0; d = resp_data_0; end
        else if (resp_valid_1) begin who = 1; d = resp_data_1; end
      end
      if (op == 3) begin
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
      end
      n_vec++;
      if (who !== op % 2) begin
        n_err++;
        $display("FAIL fair_order[%0d]: got %0d expected %0d", op, who, op % 2);
      end
      n_vec++;
      if (d !== ((op % 2 == 0) ? 8'd3 : 8'd30)) begin
        n_err++;
        $display("FAIL fair_data[%0d]: got %0d expected %0d", op, d, (op % 2 == 0) ? 3 : 30);
      end
    end
    step();
  endtask

  task automatic test_div_zero();
    int launches;
    launches = n_launch;
    req_valid_1 = 1'b1; req_a_1 = 8'd20; req_b_1 = 8'd0; req_op_1 = 2'b11;
    #1;
    n_vec++;
    if (req_ready_1 !== 1'b1) begin
      n_err++;
      $display("FAIL div0_ready: got %b expected 1", req_ready_1);
    end
    step();
    req_valid_1 = 1'b0;
    n_vec++;
    if ({alu_valid, resp_valid_1, resp_data_1, resp_err_1, resp_valid_0} !== {1'b0, 1'b1, 8'hFF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL div0_resp: got av=%b v1=%b d1=%h e1=%b v0=%b expected 0 1 ff 1 0",
               alu_valid, resp_valid_1, resp_data_1, resp_err_1, resp_valid_0);
    end
    step();
    step();
    n_vec++;
    if ({resp_valid_1, n_launch - launches} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL div0_after: got v1=%b launches=%0d expected 0 0", resp_valid_1, n_launch - launches);
    end
  endtask

  task automatic test_timeout();
    int cyc; logic [7:0] d; logic e;
    alu_en = 1'b0;
    req_valid_0 = 1'b1; req_a_0 = 8'd1; req_b_0 = 8'd1; req_op_0 = 2'b00;
    step();
    req_valid_0 = 1'b0;
    wait_resp(0, 30, cyc, d, e);
    n_vec++;
    if (cyc + 1 !== 2 + TO) begin
      n_err++;
      $display("FAIL tmo_latency: got %0d expected %0d", cyc + 1, 2 + TO);
    end
    n_vec++;
    if ({d, e} !== {8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL tmo_resp: got data=%h err=%b expected 00 1", d, e);
    end
    alu_en = 1'b1;
    alu_k  = 3;
    step();
    req_valid_1 = 1'b1; req_a_1 = 8'd9; req_b_1 = 8'd4; req_op_1 = 2'b01;
    step();
    req_valid_1 = 1'b0;
    wait_resp(1, 20, cyc, d, e);
    n_vec++;
    if ({d, e} !== {8'd5, 1'b0} || cyc + 1 !== 5) begin
      n_err++;
      $display("FAIL tmo_next: got data=%0d err=%b lat=%0d expected 5 0 5", d, e, cyc + 1);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc; int seen; logic [7:0] d; logic e;
    alu_en = 1'b0;
    step();
    req_valid_0 = 1'b1; req_a_0 = 8'd7; req_b_0 = 8'd7; req_op_0 = 2'b10;
    step();
    req_valid_0 = 1'b0;
    step();
    step();
    req_valid_1 = 1'b1; req_a_1 = 8'd1; req_b_1 = 8'd1; req_op_1 = 2'b00;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({alu_valid, alu_in, alu_op_codes, req_ready_0, req_ready_1, resp_valid_0, resp_valid_1} !== 23'h0) begin
      n_err++;
      $display("FAIL midrst_outputs: got av=%b in=%h op=%b rdy=%b%b v=%b%b expected all 0",
               alu_valid, alu_in, alu_op_codes, req_ready_0, req_ready_1, resp_valid_0, resp_valid_1);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (resp_valid_0 || resp_valid_1) seen++;
    end
    req_valid_1 = 1'b0;
    rst = 1'b1;
    alu_en = 1'b1;
    alu_k  = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (resp_valid_0 || resp_valid_1) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midrst_noresp: got %0d responses expected 0", seen);
    end
    req_valid_0 = 1'b1; req_a_0 = 8'd20; req_b_0 = 8'd4; req_op_0 = 2'b00;
    step();
    req_valid_0 = 1'b0;
    wait_resp(0, 20, cyc, d, e);
    n_vec++;
    if ({d, e} !== {8'd24, 1'b0} || cyc + 1 !== 3) begin
      n_err++;
      $display("FAIL midrst_after: got data=%0d err=%b lat=%0d expected 24 0 3", d, e, cyc + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid_0 = 1'b0; req_a_0 = 8'h00; req_b_0 = 8'h00; req_op_0 = 2'b00;
    req_valid_1 = 1'b0; req_a_1 = 8'h00; req_b_1 = 8'h00; req_op_1 = 2'b00;
    alu_o = 8'h00;
    alu_ready = 1'b0;
    step();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_div_zero();
    test_timeout();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
